// File: rtl/vga_pixel_mixer.sv
// vga_pixel_mixer: pipelined VGA colour output stage.
//
// Picks one RGB value per pixel from the screen layers in fixed priority order
// (start screen, game over, text ROM, game field, score/time), applies the
// game-over blink dimming and drives the DAC pins two cycles after the inputs.
//
// Ports:
//   clock_25          pixel clock
//   reset             synchronous, active-low reset
//   display_area      high inside the visible area
//   frame_start       one-cycle pulse per frame (blink timing)
//   en_start_game     start-screen layer enable
//   en_game_over      game-over layer enable
//   datarom           text ROM pixel
//   game_enable       game-field region
//   score_time_enable score/time region
//   color_data        palette index for the game field
//   pal_wr_en/addr/rgb palette write port, data packed {r,g,b}
//   red/green/blue    colour channels, 2-cycle latency
//   de_out            display_area aligned with RGB
//   blink_phase       current blink phase
//
// Build option: define VGA_PALETTE_WR_EN to make the palette a writable register
// array. Without it the palette is constant at its defaults and the write port
// is ignored.
module vga_pixel_mixer #(
  parameter int unsigned CH_W         = 10,
  parameter int unsigned PAL_BITS     = 2,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic                  clock_25,
  input  logic                  reset,
  input  logic                  display_area,
  input  logic                  frame_start,
  input  logic                  en_start_game,
  input  logic                  en_game_over,
  input  logic                  datarom,
  input  logic                  game_enable,
  input  logic                  score_time_enable,
  input  logic [PAL_BITS-1:0]   color_data,
  input  logic                  pal_wr_en,
  input  logic [PAL_BITS-1:0]   pal_wr_addr,
  input  logic [3*CH_W-1:0]     pal_wr_rgb,
  output logic [CH_W-1:0]       red,
  output logic [CH_W-1:0]       green,
  output logic [CH_W-1:0]       blue,
  output logic                  de_out,
  output logic                  blink_phase
);

  localparam int unsigned PAL_N = 2 ** PAL_BITS;
  localparam int unsigned RGB_W = 3 * CH_W;
  localparam int unsigned CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CH_W-1:0] C_ZERO = '0;
  localparam logic [CH_W-1:0] C_FULL = '1;
  localparam logic [CH_W-1:0] C_HALF = CH_W'(1) << (CH_W - 1);
  localparam logic [CH_W-1:0] C_QTR  = CH_W'(1) << (CH_W - 2);
  localparam logic [CH_W-1:0] C_3Q   = CH_W'(3) << (CH_W - 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

  function automatic logic [RGB_W-1:0] pal_default(input logic [PAL_BITS-1:0] idx);
    logic [RGB_W-1:0] v;
    v = '0;
    if (32'(idx) == 32'd1) v = {C_HALF, C_FULL, C_ZERO};
    if (32'(idx) == 32'd2) v = {C_FULL, C_QTR, C_QTR};
    if (32'(idx) == 32'd3) v = {C_FULL, C_FULL, C_FULL};
    return v;
  endfunction

  logic [RGB_W-1:0] w_pal_game;
  logic [RGB_W-1:0] w_pal_score;
  logic [RGB_W-1:0] w_pal_over;

`ifdef VGA_PALETTE_WR_EN
  logic [RGB_W-1:0] r_pal [PAL_N];

  // Reads below see the pre-write value; a write lands at the edge.
  always_ff @(posedge clock_25) begin
    if (!reset) begin
      for (int i = 0; i < int'(PAL_N); i++) r_pal[i] <= pal_default(PAL_BITS'(i));
    end else if (pal_wr_en) begin
      r_pal[pal_wr_addr] <= pal_wr_rgb;
    end
  end

  assign w_pal_game  = r_pal[color_data];
  assign w_pal_score = r_pal[PAL_BITS'(1)];
  assign w_pal_over  = r_pal[PAL_BITS'(2)];
`else
  logic w_unused_wr;
  assign w_unused_wr = ^{pal_wr_en, pal_wr_addr, pal_wr_rgb, PAL_N[0]};

  assign w_pal_game  = pal_default(color_data);
  assign w_pal_score = pal_default(PAL_BITS'(1));
  assign w_pal_over  = pal_default(PAL_BITS'(2));
`endif

  // Stage 1: layer selection.
  logic [RGB_W-1:0] w_sel_rgb;
  logic             w_sel_go;

  always_comb begin
    w_sel_rgb = '0;
    w_sel_go  = 1'b0;
    if (!display_area)          w_sel_rgb = '0;
    else if (en_start_game)     w_sel_rgb = {C_QTR, C_3Q, C_FULL};
    else if (en_game_over) begin
      w_sel_rgb = w_pal_over;
      w_sel_go  = 1'b1;
    end
    else if (datarom)           w_sel_rgb = {C_FULL, C_FULL, C_FULL};
    else if (game_enable)       w_sel_rgb = w_pal_game;
    else if (score_time_enable) w_sel_rgb = w_pal_score;
    else                        w_sel_rgb = '0;
  end

  logic [RGB_W-1:0] r_s1_rgb;
  logic             r_s1_go;
  logic             r_s1_de;
  logic [CH_W-1:0]  r_red;
  logic [CH_W-1:0]  r_green;
  logic [CH_W-1:0]  r_blue;
  logic             r_de;
  logic [CNT_W-1:0] r_cnt;
  logic             r_blink;

  always_ff @(posedge clock_25) begin
    if (!reset) begin
      r_s1_rgb <= '0;
      r_s1_go  <= 1'b0;
      r_s1_de  <= 1'b0;
    end else begin
      r_s1_rgb <= w_sel_rgb;
      r_s1_go  <= w_sel_go;
      r_s1_de  <= display_area;
    end
  end

  // Stage 2: halve every channel of a game-over pixel during the dim phase.
  logic [CH_W-1:0] w_r1, w_g1, w_b1;
  logic            w_dim;
  assign {w_r1, w_g1, w_b1} = r_s1_rgb;
  assign w_dim = r_s1_go & r_blink;

  always_ff @(posedge clock_25) begin
    if (!reset) begin
      r_red   <= '0;
      r_green <= '0;
      r_blue  <= '0;
      r_de    <= 1'b0;
    end else begin
      r_red   <= w_dim ? (w_r1 >> 1) : w_r1;
      r_green <= w_dim ? (w_g1 >> 1) : w_g1;
      r_blue  <= w_dim ? (w_b1 >> 1) : w_b1;
      r_de    <= r_s1_de;
    end
  end

  // Blink timer runs only while the game-over layer is enabled; dropping the
  // enable wins over a coincident frame_start.
  always_ff @(posedge clock_25) begin
    if (!reset || !en_game_over) begin
      r_cnt   <= '0;
      r_blink <= 1'b0;
    end else if (frame_start) begin
      if (r_cnt == CNT_LAST) begin
        r_cnt   <= '0;
        r_blink <= ~r_blink;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign red         = r_red;
  assign green       = r_green;
  assign blue        = r_blue;
  assign de_out      = r_de;
  assign blink_phase = r_blink;

endmodule

// File: tb/tb_vga_pixel_mixer.sv
module tb_vga_pixel_mixer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        display_area = 1'b0, frame_start = 1'b0, en_start_game = 1'b0;
  logic        en_game_over = 1'b0, datarom = 1'b0, game_enable = 1'b0;
  logic        score_time_enable = 1'b0, pal_wr_en = 1'b0;
  logic [1:0]  color_data = '0, pal_wr_addr = '0;
  logic [29:0] pal_wr_rgb = '0;
  logic [9:0]  red, green, blue;
  logic        de_out, blink_phase;

  vga_pixel_mixer #(
    .CH_W        (10),
    .PAL_BITS    (2),
    .BLINK_FRAMES(2)
  ) u_dut (
    .clock_25         (clk),
    .reset            (reset),
    .display_area     (display_area),
    .frame_start      (frame_start),
    .en_start_game    (en_start_game),
    .en_game_over     (en_game_over),
    .datarom          (datarom),
    .game_enable      (game_enable),
    .score_time_enable(score_time_enable),
    .color_data       (color_data),
    .pal_wr_en        (pal_wr_en),
    .pal_wr_addr      (pal_wr_addr),
    .pal_wr_rgb       (pal_wr_rgb),
    .red              (red),
    .green            (green),
    .blue             (blue),
    .de_out           (de_out),
    .blink_phase      (blink_phase)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        da, sg, go, rom, ge, st;
    logic [1:0]  cd;
    logic [29:0] rgb;
    logic        de;
    string       name;
  } vec_t;

  typedef struct {
    logic        chk;
    logic [30:0] exp;
    string       name;
  } sb_t;

  sb_t q[$];
  int  n_pass = 0;
  int  n_total = 0;

  localparam logic [29:0] WHITE = {10'h3FF, 10'h3FF, 10'h3FF};
  localparam logic [29:0] PAL1  = {10'h200, 10'h3FF, 10'h000};
  localparam logic [29:0] PAL2  = {10'h3FF, 10'h100, 10'h100};
  localparam logic [29:0] START = {10'h100, 10'h300, 10'h3FF};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  // One clock: queue the expectation for the inputs now applied, then compare
  // the output that belongs to the inputs from the previous step.
  task automatic step(input logic chk, input logic [29:0] rgb, input logic de,
                      input string name);
    sb_t e, f;
    e.chk = chk;
    e.exp = {rgb, de};
    e.name = name;
    q.push_back(e);
    @(posedge clk);
    #1;
    if (q.size() >= 2) begin
      f = q.pop_front();
      if (f.chk) check(f.name, 32'({red, green, blue, de_out}), 32'(f.exp));
    end
  endtask

  task automatic hold();
    step(1'b0, '0, 1'b0, "idle");
  endtask

  task automatic flush();
    hold();
    q.delete();
  endtask

  task automatic clear_inputs();
    display_area = 0; frame_start = 0; en_start_game = 0; en_game_over = 0;
    datarom = 0; game_enable = 0; score_time_enable = 0; color_data = '0;
    pal_wr_en = 0; pal_wr_addr = '0; pal_wr_rgb = '0;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    hold();
    frame_start = 1'b0;
    hold();
  endtask

  function automatic vec_t mk(input logic da, sg, go, rom, ge, st, input logic [1:0] cd,
                              input logic [29:0] rgb, input logic de, input string name);
    vec_t v;
    v.da = da; v.sg = sg; v.go = go; v.rom = rom; v.ge = ge; v.st = st; v.cd = cd;
    v.rgb = rgb; v.de = de; v.name = name;
    return v;
  endfunction

  vec_t tbl[13];

  initial begin
    //            da sg go rom ge st cd  rgb    de
    tbl[0]  = mk(1, 0, 0, 0, 1, 0, 1, PAL1,  1, "game_idx1");
    tbl[1]  = mk(1, 0, 0, 1, 1, 0, 1, WHITE, 1, "rom_over_game");
    tbl[2]  = mk(1, 1, 1, 0, 0, 0, 0, START, 1, "start_over_gameover");
    tbl[3]  = mk(0, 1, 1, 0, 0, 0, 0, '0,    0, "blank_area");
    tbl[4]  = mk(1, 0, 0, 0, 1, 0, 0, '0,    1, "game_idx0");
    tbl[5]  = mk(1, 0, 0, 0, 1, 0, 2, PAL2,  1, "game_idx2");
    tbl[6]  = mk(1, 0, 0, 0, 1, 0, 3, WHITE, 1, "game_idx3");
    tbl[7]  = mk(1, 0, 0, 0, 0, 1, 0, PAL1,  1, "score_time");
    tbl[8]  = mk(1, 0, 1, 0, 0, 0, 0, PAL2,  1, "gameover_phase0");
    tbl[9]  = mk(1, 0, 0, 1, 0, 1, 0, WHITE, 1, "rom_over_score");
    tbl[10] = mk(1, 0, 0, 0, 0, 0, 0, '0,    1, "no_layer");
    tbl[11] = mk(1, 0, 0, 0, 1, 1, 2, PAL2,  1, "game_over_score");
    tbl[12] = mk(0, 0, 0, 1, 0, 0, 0, '0,    0, "rom_blanked");

    // Reset
    @(posedge clk); #1;
    check("reset_hold", 32'({red, green, blue, de_out, blink_phase}), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    hold(); hold();
    check("reset_state", 32'({red, green, blue, de_out, blink_phase}), 32'd0);
    q.delete();

    // Back-to-back table vectors exercise priority and latency together.
    for (int i = 0; i < 13; i++) begin
      display_area = tbl[i].da; en_start_game = tbl[i].sg; en_game_over = tbl[i].go;
      datarom = tbl[i].rom; game_enable = tbl[i].ge; score_time_enable = tbl[i].st;
      color_data = tbl[i].cd;
      step(1'b1, tbl[i].rgb, tbl[i].de, tbl[i].name);
    end
    clear_inputs();
    flush();

    // Palette write coinciding with a lookup of the same entry.
    display_area = 1; game_enable = 1; color_data = 2'd3;
    pal_wr_en = 1; pal_wr_addr = 2'd3; pal_wr_rgb = {10'h155, 10'h0AA, 10'h3C0};
    step(1'b1, WHITE, 1'b1, "pal_same_cycle_old");
    pal_wr_en = 0; pal_wr_rgb = '0;
`ifdef VGA_PALETTE_WR_EN
    step(1'b1, {10'h155, 10'h0AA, 10'h3C0}, 1'b1, "pal_next_cycle_new");
`else
    step(1'b1, WHITE, 1'b1, "pal_const_white");
`endif
    clear_inputs();
    flush();

    // Blink with BLINK_FRAMES=2.
    display_area = 1; en_game_over = 1;
    hold();
    frame_start = 1'b1; hold(); frame_start = 1'b0;
    check("blink_one_pulse", 32'(blink_phase), 32'd0);
    hold();
    pulse_frame();
    check("blink_phase1", 32'(blink_phase), 32'd1);
    step(1'b1, {10'h1FF, 10'h080, 10'h080}, 1'b1, "blink_dim");
    flush();
    pulse_frame(); pulse_frame();
    check("blink_phase0", 32'(blink_phase), 32'd0);
    step(1'b1, PAL2, 1'b1, "blink_bright");
    flush();
    pulse_frame(); pulse_frame();
    check("blink_phase1_again", 32'(blink_phase), 32'd1);
    en_game_over = 0; frame_start = 1;   // clear beats frame_start
    hold();
    frame_start = 0;
    check("blink_clear_on_drop", 32'(blink_phase), 32'd0);
    clear_inputs();
    flush();

    // Reset during a dimmed game-over frame with the counter mid-count.
    display_area = 1; en_game_over = 1;
    pulse_frame(); pulse_frame();
    check("pre_reset_phase1", 32'(blink_phase), 32'd1);
    pulse_frame();
    hold();
    reset = 1'b0;
    @(posedge clk); #1;
    check("reset_midframe", 32'({red, green, blue, de_out, blink_phase}), 32'd0);
    reset = 1'b1;
    q.delete();
    pulse_frame();
    check("cnt_cleared_by_reset", 32'(blink_phase), 32'd0);
    en_game_over = 0; game_enable = 1; color_data = 2'd3;
    step(1'b1, WHITE, 1'b1, "pal_default_after_reset");
    flush();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
